// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract front-end.
package nibble_serial_addsub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibble index width; a single-nibble build still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Request/result handshake bundle for nibble_serial_addsub.
interface nibble_serial_addsub_if
  import nibble_serial_addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_ovf, out_zero
  );

endinterface

// File: rtl/nibble_serial_addsub_nibble_addsub.sv
// 4-bit ripple adder/subtractor slice; m=1 inverts b for two's-complement subtract.
module nibble_addsub
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  input  logic                i_m,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout,
  output logic                o_c3
);

  logic [NIBBLE_W:0]   w_c;
  logic [NIBBLE_W-1:0] w_bx;

  always_comb begin
    w_bx   = i_b ^ {NIBBLE_W{i_m}};
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      o_sum[i]  = i_a[i] ^ w_bx[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & w_bx[i]) | (w_c[i] & (i_a[i] ^ w_bx[i]));
    end
  end

  assign o_cout = w_c[NIBBLE_W];
  assign o_c3   = w_c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Wide add/subtract done one nibble per clock, LS nibble first, carry chained in a register.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
)
(
  input logic                   clk,
  input logic                   rst,
  nibble_serial_addsub_if.slave bus
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned KW = idx_w(NIBBLES);
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic          r_op;
  logic          r_carry;
  logic [KW-1:0] r_k;

  logic          r_in_ready;
  logic          r_out_valid;
  logic [W-1:0]  r_out_result;
  logic          r_out_carry;
  logic          r_out_ovf;
  logic          r_out_zero;

  logic [KW+1:0]         w_base;
  logic [NIBBLE_W-1:0]   w_a_nib;
  logic [NIBBLE_W-1:0]   w_b_nib;
  logic [NIBBLE_W-1:0]   w_sum;
  logic                  w_cout;
  logic                  w_c3;
  logic [W-1:0]          w_res_next;

  assign w_base = {r_k, 2'b00};

  // Select the active nibble and merge its sum into the result image.
  always_comb begin
    w_a_nib    = r_a[w_base +: NIBBLE_W];
    w_b_nib    = r_b[w_base +: NIBBLE_W];
    w_res_next = r_res;
    w_res_next[w_base +: NIBBLE_W] = w_sum;
  end

  nibble_addsub u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .i_m    (r_op),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_c3   (w_c3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_op         <= OP_ADD;
      r_carry      <= 1'b0;
      r_k          <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_carry  <= 1'b0;
      r_out_ovf    <= 1'b0;
      r_out_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (r_in_ready && bus.in_valid) begin
            r_a        <= bus.in_a;
            r_b        <= bus.in_b;
            r_op       <= bus.in_op;
            r_carry    <= bus.in_op;
            r_k        <= '0;
            r_res      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_k     <= r_k + KW'(1);
          // MSB nibble: its carry-in to bit 3 and carry-out give the flags.
          if (r_k == K_LAST) begin
            r_out_result <= w_res_next;
            r_out_carry  <= w_cout;
            r_out_ovf    <= w_c3 ^ w_cout;
            r_out_zero   <= (w_res_next == '0);
            r_out_valid  <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_carry  = r_out_carry;
  assign bus.out_ovf    = r_out_ovf;
  assign bus.out_zero   = r_out_zero;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (NIBBLES=4).
module tb_nibble_serial_addsub;
  import nibble_serial_addsub_pkg::*;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned TMO     = 40;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_addsub_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  vec_t tbl[7];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic op,
                              logic [15:0] res, logic c, logic v, logic z);
    vec_t t;
    t.a = a; t.b = b; t.op = op;
    t.e.res = res; t.e.c = c; t.e.v = v; t.e.z = z;
    return t;
  endfunction

  // Golden model: plain 17-bit arithmetic, overflow from operand/result signs.
  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic op);
    exp_t r;
    logic [16:0] s;
    if (op == OP_SUB) begin
      s   = {1'b0, a} - {1'b0, b};
      r.c = (a >= b);
      r.v = (a[15] != b[15]) && (s[15] != a[15]);
    end else begin
      s   = {1'b0, a} + {1'b0, b};
      r.c = s[16];
      r.v = (a[15] == b[15]) && (s[15] != a[15]);
    end
    r.res = s[15:0];
    r.z   = (s[15:0] == 16'h0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty got=result exp=none");
    end else begin
      e = sb.pop_front();
      chk("result", 32'(bus.out_result), 32'(e.res));
      chk("carry",  32'(bus.out_carry),  32'(e.c));
      chk("ovf",    32'(bus.out_ovf),    32'(e.v));
      chk("zero",   32'(bus.out_zero),   32'(e.z));
    end
  endtask

  task automatic wait_in_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < TMO; n++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL in_ready_timeout got=0 exp=1");
  endtask

  // Called at the first negedge after the input handshake edge.
  task automatic wait_out_valid(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int lat;
    @(negedge clk);
    bus.in_a = v.a; bus.in_b = v.b; bus.in_op = v.op; bus.in_valid = 1'b1;
    wait_in_ready(ok);
    if (!ok) return;
    sb.push_back(v.e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out_valid(lat);
    chk("latency", 32'(lat), 32'(NIBBLES + 1));
    if (bus.out_valid === 1'b1) compare_out();
    @(negedge clk);
    chk("valid_drop", 32'(bus.out_valid), 32'd0);
    chk("ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),   32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid),  32'd0);
    chk({tag, "_result"},    32'(bus.out_result), 32'd0);
    chk({tag, "_carry"},     32'(bus.out_carry),  32'd0);
    chk({tag, "_ovf"},       32'(bus.out_ovf),    32'd0);
    chk({tag, "_zero"},      32'(bus.out_zero),   32'd0);
  endtask

  initial begin
    bit   ok;
    int   lat;
    int   t_prev;
    bit   seen;
    vec_t v;

    tbl[0] = mk(16'h1234, 16'h0FCD, OP_ADD, 16'h2201, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    tbl[2] = mk(16'h0007, 16'h0005, OP_SUB, 16'h0002, 1'b1, 1'b0, 1'b0);
    tbl[3] = mk(16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0);
    tbl[4] = mk(16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
    tbl[5] = mk(16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    tbl[6] = mk(16'h0000, 16'h0000, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1);

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = OP_ADD;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Backpressure: hold the result 10 cycles while a second request waits.
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_a = 16'h1111; bus.in_b = 16'h2222; bus.in_op = OP_ADD; bus.in_valid = 1'b1;
    wait_in_ready(ok);
    sb.push_back(model(16'h1111, 16'h2222, OP_ADD));
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out_valid(lat);
    chk("bp_latency", 32'(lat), 32'(NIBBLES + 1));
    bus.in_a = 16'h0100; bus.in_b = 16'h0001; bus.in_op = OP_SUB; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid",  32'(bus.out_valid),  32'd1);
      chk("bp_result", 32'(bus.out_result), 32'h3333);
      chk("bp_ready",  32'(bus.in_ready),   32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    compare_out();
    @(negedge clk);
    chk("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("bp_ready_back", 32'(bus.in_ready),  32'd1);
    sb.push_back(model(16'h0100, 16'h0001, OP_SUB));
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out_valid(lat);
    chk("bp2_latency", 32'(lat), 32'(NIBBLES + 1));
    if (bus.out_valid === 1'b1) compare_out();
    @(negedge clk);

    // Reset two cycles into RUN abandons the operation.
    bus.in_a = 16'h1234; bus.in_b = 16'h1111; bus.in_op = OP_ADD; bus.in_valid = 1'b1;
    wait_in_ready(ok);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort");
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back with out_ready tied high.
    bus.out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      v.a  = 16'($urandom_range(0, 65535));
      v.b  = 16'($urandom_range(0, 65535));
      v.op = (i == 1) ? OP_SUB : logic'($urandom_range(0, 1));
      bus.in_a = v.a; bus.in_b = v.b; bus.in_op = v.op; bus.in_valid = 1'b1;
      wait_in_ready(ok);
      if (!ok) break;
      if (i > 0) chk("b2b_spacing", 32'(cyc - t_prev), 32'(NIBBLES + 2));
      t_prev = cyc;
      sb.push_back(model(v.a, v.b, v.op));
      @(negedge clk);
      wait_out_valid(lat);
      chk("b2b_latency", 32'(lat), 32'(NIBBLES + 1));
      if (bus.out_valid === 1'b1) compare_out();
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
